// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for alu_slice_sequencer:
//   - opcode encodings driven onto the 2-bit ALU slice S input
//   - sequencer FSM state encodings (ST_CAPT is reached only when
//     ALU_SEQ_SETTLE_EN is defined)
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_CAPT = 2'b10
  } state_t;

endpackage

// File: rtl/alu_slice_sequencer.sv
// ---------------------------------------------------------------------------
// alu_slice_sequencer
// Runs a WIDTH-bit ALU operation through one external combinational 2-bit
// cascadable ALU slice, two bits per pass, LSB pair first. The carry is
// chained between passes through r_carry, and the zero flag is accumulated
// across passes.
//
// Optional build macro: ALU_SEQ_SETTLE_EN
//   defined   : each pass is two cycles (RUN = drive, CAPT = capture), which
//               gives the slice a full extra cycle to settle.
//   undefined : one cycle per pass.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, a, b, cin request handshake and operands (sampled when idle)
//   busy                operation in progress
//   done                one-cycle completion pulse
//   result, cout, v, z  full-width result and flags, held until next done
//   slice_a/b/s/ci      drives to the external slice (0 when idle)
//   slice_r/co/v/z      returns from the external slice
// ---------------------------------------------------------------------------
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             v,
  output logic             z,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic [1:0]       slice_s,
  output logic             slice_ci,
  input  logic [1:0]       slice_r,
  input  logic             slice_co,
  input  logic             slice_v,
  input  logic             slice_z
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_zacc;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_cout;
  logic             r_v;
  logic             r_z;
  logic [IDX_W:0]   w_pos;
  logic             w_accept;
  logic             w_capt;
  logic             w_last;

  // Bit position of the current pair within the operands.
  assign w_pos    = {r_idx, 1'b0};
  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef ALU_SEQ_SETTLE_EN
  assign w_capt = (r_state == ST_CAPT);
`else
  assign w_capt = (r_state == ST_RUN);
`endif

  assign w_last = w_capt && (r_idx == IDX_W'(N - 1));

  // Shadow with the pair returned by the slice this cycle merged in; this is
  // also what becomes the result on the final pass.
  always_comb begin
    w_shadow_nxt               = r_shadow;
    w_shadow_nxt[w_pos +: 2]   = slice_r;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
`ifdef ALU_SEQ_SETTLE_EN
      ST_RUN:  w_state_nxt = ST_CAPT;
`else
      ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
`endif
      ST_CAPT: w_state_nxt = w_last ? ST_IDLE : ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. Slice inputs are forced to 0 while idle.
  always_comb begin
    busy     = (r_state != ST_IDLE);
    slice_a  = 2'b00;
    slice_b  = 2'b00;
    slice_s  = 2'b00;
    slice_ci = 1'b0;
    if (r_state != ST_IDLE) begin
      slice_a  = r_a[w_pos +: 2];
      slice_b  = r_b[w_pos +: 2];
      slice_s  = r_op;
      slice_ci = r_carry;
    end
  end

  // Operand latch, pass counter, carry chain and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_shadow <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_op    <= op;
        r_idx   <= '0;
        // Carry-in only has meaning for ADD; other ops see Ci = 0.
        r_carry <= (op == OP_ADD) ? cin : 1'b0;
        r_zacc  <= 1'b1;
      end else if (w_capt) begin
        r_shadow <= w_shadow_nxt;
        r_carry  <= slice_co;
        r_zacc   <= r_zacc & slice_z;
        r_idx    <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_last) begin
        r_result <= w_shadow_nxt;
        r_cout   <= slice_co;
        r_v      <= slice_v;
        r_z      <= r_zacc & slice_z;
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign v      = r_v;
  assign z      = r_z;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_slice_sequencer
// Directed bench for alu_slice_sequencer (WIDTH=8) with a behavioural 2-bit
// ALU slice attached. Expected results are hand-computed and queued when a
// request is issued; a monitor pops them whenever done is seen.
// ---------------------------------------------------------------------------
module tb_alu_slice_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 8;
`ifdef ALU_SEQ_SETTLE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         zf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, v, z;
  logic [W-1:0] result;
  logic [1:0]   slice_a, slice_b, slice_s, slice_r;
  logic         slice_ci, slice_co, slice_v, slice_z;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_slice_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .v(v), .z(z),
    .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s), .slice_ci(slice_ci),
    .slice_r(slice_r), .slice_co(slice_co), .slice_v(slice_v), .slice_z(slice_z)
  );

  // Behavioural 2-bit cascadable ALU slice.
  logic [2:0] sum;
  always_comb begin
    sum      = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_ci};
    slice_co = 1'b0;
    slice_v  = 1'b0;
    case (slice_s)
      OP_ADD: begin
        slice_r  = sum[1:0];
        slice_co = sum[2];
        slice_v  = (slice_a[1] == slice_b[1]) && (sum[1] != slice_a[1]);
      end
      OP_XOR:  slice_r = slice_a ^ slice_b;
      OP_AND:  slice_r = slice_a & slice_b;
      default: slice_r = slice_a;
    endcase
    slice_z = (slice_r == 2'b00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout",   32'(cout),   32'(e.co));
        chk("v",      32'(v),      32'(e.ov));
        chk("z",      32'(z),      32'(e.zf));
      end
    end
  end

  // Issue one request from the current phase (#1 after an edge), then wait
  // for done, checking latency and busy length. glitch>0 pulses a second
  // start during that busy cycle, which must be ignored.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ci,
                       input exp_t e, input int glitch);
    int cyc;
    int bcnt;
    op = o; a = av; b = bv; cin = ci; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (cyc == 0) begin
        chk("slice_s_first", 32'(slice_s), 32'(o));
        chk("slice_a_first", 32'(slice_a), 32'(av[1:0]));
        chk("slice_ci_first", 32'(slice_ci), 32'((o == OP_ADD) ? ci : 1'b0));
      end
      if (glitch > 0 && cyc == glitch) begin
        op = OP_ADD; a = 8'h22; b = 8'h00; cin = 1'b1; start = 1'b1;
      end
      if (glitch > 0 && cyc == glitch + 1) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'(LAT));
    chk("busy_len", 32'(bcnt), 32'(LAT));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_outputs", 32'({busy, done, result, cout, v, z}), 32'd0);
    chk("rst_slice", 32'({slice_a, slice_b, slice_s, slice_ci}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD and flag cases
    do_op(OP_ADD, 8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}, 0);
    do_op(OP_ADD, 8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}, 0);
    do_op(OP_ADD, 8'h0F, 8'h00, 1'b1, '{8'h10, 1'b0, 1'b0, 1'b0}, 0);
    // Logic ops; cin must be ignored for XOR
    do_op(OP_XOR, 8'hA5, 8'hA5, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1}, 0);
    do_op(OP_AND, 8'hF0, 8'h3C, 1'b0, '{8'h30, 1'b0, 1'b0, 1'b0}, 0);
    do_op(OP_PASS, 8'h5A, 8'hFF, 1'b0, '{8'h5A, 1'b0, 1'b0, 1'b0}, 0);
    // start while busy ignored; next request issued in the done cycle
    do_op(OP_PASS, 8'h11, 8'h00, 1'b0, '{8'h11, 1'b0, 1'b0, 1'b0}, 2);
    do_op(OP_XOR, 8'h0F, 8'hFF, 1'b0, '{8'hF0, 1'b0, 1'b0, 1'b0}, 0);

    // Asynchronous reset in the middle of an operation
    op = OP_ADD; a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_outputs", 32'({busy, done, result, cout, v, z}), 32'd0);
    chk("midrun_rst_slice", 32'({slice_a, slice_b, slice_s, slice_ci}), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(OP_ADD, 8'h03, 8'h04, 1'b0, '{8'h07, 1'b0, 1'b0, 1'b0}, 0);

    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
